// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int WAIT_CYC_DEF = 2;
  localparam int WE_W         = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between fetch and data requests.
// MEM_ARB_RR_EN: alternate on ties using the previous grant type (last_d).
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
(
  input  logic dce,
  input  logic ice,
  input  logic flush,
`ifdef MEM_ARB_RR_EN
  input  logic last_d,
`endif
  output logic gnt_any,
  output logic gnt_data
);

  logic fetch_ok;

  always_comb begin
    fetch_ok = ice && !flush;
    gnt_any  = dce || fetch_ok;
`ifdef MEM_ARB_RR_EN
    // on a tie the requester that was not served last goes first
    gnt_data = dce && !(fetch_ok && last_d);
`else
    gnt_data = dce;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between instruction fetch and MEM-stage data.
// Optional round-robin tie-break when MEM_ARB_RR_EN is defined.
//
// state    | meaning
// ARB_IDLE | no access; grant may be made this cycle
// ARB_BUSY | memory command driven, cnt counts down the wait states
// ARB_DONE | completion pulse cycle; no grant, memory idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              ice,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              flush,
  input  logic              dce,
  input  logic [WE_W-1:0]   dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [DATA_W-1:0] dout,
  output logic              d_valid,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              mem_ce,
  output logic [WE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_d;
  logic             kill;
  logic             gnt_any;
  logic             gnt_data;

`ifdef MEM_ARB_RR_EN
  logic             last_d;
`endif

  mem_arb_grant u_grant (
    .dce      (dce),
    .ice      (ice),
    .flush    (flush),
`ifdef MEM_ARB_RR_EN
    .last_d   (last_d),
`endif
    .gnt_any  (gnt_any),
    .gnt_data (gnt_data)
  );

  assign stallreq_if  = ice && !flush && !inst_valid;
  assign stallreq_mem = dce && !d_valid;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      gnt_d      <= 1'b0;
      kill       <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
      dout       <= '0;
      d_valid    <= 1'b0;
      mem_ce     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_any) begin
            gnt_d     <= gnt_data;
            mem_ce    <= 1'b1;
            mem_addr  <= gnt_data ? daddr : iaddr;
            mem_we    <= gnt_data ? dwe : '0;
            mem_wdata <= din;
            cnt       <= CNT_W'(WAIT_CYC - 1);
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // a flush only cancels the fetch result; the memory cycle still runs out
          if (flush && !gnt_d)
            kill <= 1'b1;
          if (cnt == '0) begin
            mem_ce <= 1'b0;
            state  <= ARB_DONE;
            if (gnt_d) begin
              dout    <= mem_rdata;
              d_valid <= 1'b1;
            end else begin
              inst       <= mem_rdata;
              inst_valid <= !(kill || flush);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARB_DONE: begin
          inst_valid <= 1'b0;
          d_valid    <= 1'b0;
          kill       <= 1'b0;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n)
      last_d <= 1'b0;
    else if (state == ARB_IDLE && gnt_any)
      last_d <= gnt_data;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (WAIT_CYC=2).
module tb_mem_port_arbiter;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        ice;
  logic [31:0] iaddr;
  logic        flush;
  logic        dce;
  logic [3:0]  dwe;
  logic [31:0] daddr;
  logic [31:0] din;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] dout;
  logic        d_valid;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        mem_ce;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_inst[$];
  logic [31:0] exp_d[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2)) dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst_n    (cpu_rst_n),
    .ice          (ice),
    .iaddr        (iaddr),
    .flush        (flush),
    .dce          (dce),
    .dwe          (dwe),
    .daddr        (daddr),
    .din          (din),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .dout         (dout),
    .d_valid      (d_valid),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem),
    .mem_ce       (mem_ce),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    cpu_clk_50M = 1'b0;
    forever #5 cpu_clk_50M = ~cpu_clk_50M;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3C1D_1000;
      32'h0000_0100: return 32'h2402_0005;
      32'h0000_0104: return 32'h8C43_0004;
      32'h0000_8000: return 32'hAABB_CCDD;
      32'h0000_8004: return 32'h1357_2468;
      32'h0000_8008: return 32'h55AA_55AA;
      default:       return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign mem_rdata = mem_model(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // monitor: pops the scoreboard whenever a completion pulse is presented
  always @(negedge cpu_clk_50M) begin
    if (cpu_rst_n === 1'b1) begin
      if (inst_valid === 1'b1) begin
        if (exp_inst.size() == 0) chk("inst_unexpected", 32'd1, 32'd0);
        else chk("inst_data", inst, exp_inst.pop_front());
      end
      if (d_valid === 1'b1) begin
        if (exp_d.size() == 0) chk("dout_unexpected", 32'd1, 32'd0);
        else chk("dout_data", dout, exp_d.pop_front());
      end
    end
  end

  // waits for a completion pulse, checks its cycle count, then drops the request
  task automatic wait_lat(input bit is_d, input int exp_n, input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge cpu_clk_50M);
      if (is_d ? d_valid : inst_valid) begin
        n = i;
        break;
      end
    end
    chk(nm, n, exp_n);
    if (is_d) begin dce = 1'b0; dwe = 4'h0; end
    else ice = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_ce"}, {31'd0, mem_ce}, 32'd0);
    chk({tag, "_valids"}, {30'd0, inst_valid, d_valid}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_we"}, {28'd0, mem_we}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_dout"}, dout, 32'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit with_flush, input string tag);
    @(negedge cpu_clk_50M);
    dce = 1'b1; dwe = 4'hF; daddr = a; din = d;
    for (int i = 1; i <= 2; i++) begin
      @(negedge cpu_clk_50M);
      if (i == 1) flush = with_flush;
      else flush = 1'b0;
      #1;
      chk({tag, "_ce"}, {31'd0, mem_ce}, 32'd1);
      chk({tag, "_we"}, {28'd0, mem_we}, 32'hF);
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_wdata"}, mem_wdata, d);
      chk({tag, "_stall"}, {31'd0, stallreq_mem}, 32'd1);
    end
    @(negedge cpu_clk_50M);
    chk({tag, "_valid"}, {31'd0, d_valid}, 32'd1);
    #1 chk({tag, "_stall_done"}, {31'd0, stallreq_mem}, 32'd0);
    dce = 1'b0; dwe = 4'h0;
    @(negedge cpu_clk_50M);
    chk({tag, "_pulse_width"}, {31'd0, d_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_d;
    int t_i;
    cpu_rst_n = 1'b0;
    ice = 1'b0; iaddr = '0; flush = 1'b0;
    dce = 1'b0; dwe = '0; daddr = '0; din = '0;
    #8;
    chk_idle_outputs("reset");
    chk("reset_stalls", {30'd0, stallreq_if, stallreq_mem}, 32'd0);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;

    // single fetch
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = 32'h100;
    exp_inst.push_back(32'h2402_0005);
    #1 chk("fetch_stall_req", {31'd0, stallreq_if}, 32'd1);
    for (int i = 1; i <= 2; i++) begin
      @(negedge cpu_clk_50M);
      chk("fetch_ce", {31'd0, mem_ce}, 32'd1);
      chk("fetch_addr", mem_addr, 32'h100);
      chk("fetch_we", {28'd0, mem_we}, 32'd0);
      chk("fetch_stall", {31'd0, stallreq_if}, 32'd1);
    end
    @(negedge cpu_clk_50M);
    chk("fetch_valid", {31'd0, inst_valid}, 32'd1);
    chk("fetch_stall_done", {31'd0, stallreq_if}, 32'd0);
    chk("fetch_done_ce", {31'd0, mem_ce}, 32'd0);
    ice = 1'b0;
    @(negedge cpu_clk_50M);
    chk("fetch_pulse_width", {31'd0, inst_valid}, 32'd0);

    // stores, plain and with a flush in the middle
    exp_d.push_back(32'h1357_2468);
    store(32'h8004, 32'hDEAD_BEEF, 1'b0, "store");
    exp_d.push_back(32'h55AA_55AA);
    store(32'h8008, 32'h0BAD_F00D, 1'b1, "store_flush");

    // tie between fetch and data read
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = 32'h104;
    dce = 1'b1; daddr = 32'h8000; dwe = 4'h0;
    exp_d.push_back(32'hAABB_CCDD);
    exp_inst.push_back(32'h8C43_0004);
    t_d = 0; t_i = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge cpu_clk_50M);
      if (d_valid) begin t_d = i; dce = 1'b0; end
      if (inst_valid) begin t_i = i; ice = 1'b0; end
      if (t_d != 0 && t_i != 0) break;
    end
`ifdef MEM_ARB_RR_EN
    chk("tie_inst_cycle", t_i, 32'd3);
    chk("tie_data_cycle", t_d, 32'd7);
`else
    chk("tie_data_cycle", t_d, 32'd3);
    chk("tie_inst_cycle", t_i, 32'd7);
`endif
    ice = 1'b0; dce = 1'b0;

    // flush in the first BUSY cycle of a fetch
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = 32'h200;
    @(negedge cpu_clk_50M);
    flush = 1'b1;
    #1 chk("flush_stall_if", {31'd0, stallreq_if}, 32'd0);
    chk("flush_busy_ce", {31'd0, mem_ce}, 32'd1);
    @(negedge cpu_clk_50M);
    flush = 1'b0; ice = 1'b0;
    chk("flush_access_runs", {31'd0, mem_ce}, 32'd1);
    @(negedge cpu_clk_50M);
    chk("flush_no_valid", {31'd0, inst_valid}, 32'd0);
    chk("flush_done_ce", {31'd0, mem_ce}, 32'd0);
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = 32'h0;
    exp_inst.push_back(32'h3C1D_1000);
    wait_lat(1'b0, 3, "post_flush_lat");

    // reset in the middle of a fetch
    @(negedge cpu_clk_50M);
    ice = 1'b1; iaddr = 32'h104;
    @(negedge cpu_clk_50M);
    chk("pre_reset_ce", {31'd0, mem_ce}, 32'd1);
    #2 cpu_rst_n = 1'b0;
    ice = 1'b0;
    #1 chk_idle_outputs("midrst");
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;
    ice = 1'b1; iaddr = 32'h0;
    exp_inst.push_back(32'h3C1D_1000);
    wait_lat(1'b0, 3, "post_reset_lat");

    repeat (4) @(negedge cpu_clk_50M);
    chk("scoreboard_drained", exp_inst.size() + exp_d.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
